// File: rtl/hack_screen_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hack_screen_scanner                                          |
// | Description : Reader side of the Hack screen memory map. Reads screen RAM  |
// |               words in raster order and serializes them, bit 0 first, into |
// |               a 1-bit pixel stream with a valid/ready handshake.           |
// |               (1 = black; word bit 0 is the leftmost pixel.)               |
// | Ports       : clk, rst_n     - clock, asynchronous active-low reset        |
// |               start          - request one frame scan (ignored when busy)  |
// |               busy           - frame in progress                           |
// |               frame_done     - one-cycle pulse after the last pixel        |
// |               mem_rd/addr    - screen RAM read strobe and word address     |
// |               mem_rdata      - read data, valid 1 cycle after mem_rd       |
// |               pix_valid/ready/data - pixel stream handshake and pixel      |
// |               pix_sof/sol/eol- start-of-frame, start/end-of-line markers   |
// | Options     : SCREEN_SCAN_PREFETCH_EN - one-word prefetch buffer giving a  |
// |               gap-free stream (requires WORD_W >= 4).                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hack_screen_scanner #(
   parameter int H_PIXELS = 512,
   parameter int V_LINES  = 256,
   parameter int WORD_W   = 16,
   parameter int ADDR_W   = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_data,
   output logic              pix_sof,
   output logic              pix_sol,
   output logic              pix_eol
);

   localparam int WORDS = H_PIXELS * V_LINES / WORD_W;
   localparam int WPL   = H_PIXELS / WORD_W;
   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int COL_W = (WPL > 1) ? $clog2(WPL) : 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WPL - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_SHIFT = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;        // word currently being shifted / fetched
   logic [ADDR_W-1:0] rd_addr;     // address presented with the current read
   logic [ADDR_W-1:0] rd_addr_q;   // last issued read address (mem_addr hold)
   logic [COL_W-1:0]  col;         // word column within the line, tracks addr
   logic [WORD_W-1:0] shreg;
   logic [BIT_W-1:0]  bitcnt;
   logic              done_q;
   logic              accept;
   logic              xfer;
   logic              word_end;
   logic              frame_end;

   // A start coinciding with frame_done is dropped even though the FSM is
   // already back in IDLE.
   assign accept    = (state == S_IDLE) && start && !done_q;
   assign xfer      = (state == S_SHIFT) && pix_ready;
   assign word_end  = xfer && (bitcnt == LAST_BIT);
   assign frame_end = word_end && (addr == LAST_ADDR);

`ifdef SCREEN_SCAN_PREFETCH_EN
   logic              pf_issued;   // read of the next word already sent
   logic              pf_pending;  // read data arrives this cycle
   logic [WORD_W-1:0] pf_buf;
   logic              pf_issue;
   logic [WORD_W-1:0] pf_next;

   // Next-word read goes out once bit 1 is reached, so the data has long
   // been captured by the time the current word finishes shifting.
   assign pf_issue = (state == S_SHIFT) && (bitcnt != '0) && !pf_issued &&
                     (addr != LAST_ADDR);
   assign pf_next  = pf_pending ? mem_rdata : pf_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pf_issued  <= 1'b0;
         pf_pending <= 1'b0;
         pf_buf     <= '0;
      end else begin
         pf_pending <= pf_issue;
         if (pf_pending) begin
            pf_buf <= mem_rdata;
         end
         if (word_end) begin
            pf_issued <= 1'b0;
         end else if (pf_issue) begin
            pf_issued <= 1'b1;
         end
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and read strobe
   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      rd_addr   = addr;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_rd    = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
`ifdef SCREEN_SCAN_PREFETCH_EN
            if (pf_issue) begin
               mem_rd  = 1'b1;
               rd_addr = addr + ADDR_W'(1);
            end
            if (frame_end) begin
               state_nxt = S_IDLE;
            end
`else
            if (frame_end) begin
               state_nxt = S_IDLE;
            end else if (word_end) begin
               state_nxt = S_FETCH;
            end
`endif
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: address/column, shift register, bit counter, done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         col       <= '0;
         shreg     <= '0;
         bitcnt    <= '0;
         done_q    <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         done_q <= frame_end;
         if (mem_rd) begin
            rd_addr_q <= rd_addr;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  addr <= '0;
                  col  <= '0;
               end
            end
            S_WAIT: begin
               shreg  <= mem_rdata;
               bitcnt <= '0;
            end
            S_SHIFT: begin
               if (xfer) begin
                  if (word_end) begin
                     bitcnt <= '0;
                     if (!frame_end) begin
                        addr <= addr + ADDR_W'(1);
                        col  <= (col == LAST_COL) ? '0 : col + COL_W'(1);
                     end
`ifdef SCREEN_SCAN_PREFETCH_EN
                     // Load the next word straight from the prefetch path.
                     shreg <= frame_end ? (shreg >> 1) : pf_next;
`else
                     shreg <= shreg >> 1;
`endif
                  end else begin
                     shreg  <= shreg >> 1;
                     bitcnt <= bitcnt + BIT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs; markers are gated by pix_valid so they read 0 between pixels.
   assign busy       = (state != S_IDLE);
   assign frame_done = done_q;
   assign mem_addr   = mem_rd ? rd_addr : rd_addr_q;
   assign pix_valid  = (state == S_SHIFT);
   assign pix_data   = pix_valid && shreg[0];
   assign pix_sof    = pix_valid && (addr == '0) && (bitcnt == '0);
   assign pix_sol    = pix_valid && (col == '0) && (bitcnt == '0);
   assign pix_eol    = pix_valid && (col == LAST_COL) && (bitcnt == LAST_BIT);

endmodule
`default_nettype wire
